// File: rtl/decode_stage.sv
// RV32I decode stage: splits a fetched instruction into register indices, immediate
// and control flags, and holds issue while a source register has a write in flight.
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_uses_rs1,
  output logic            out_uses_rs2,
  output logic            out_writes_rd,
  output logic            out_illegal,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);

  // Handshake: a beat moves on in_valid & in_ready (input) and out_valid & out_ready
  // (output); the output bundle never changes while out_valid & !out_ready.

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd_raw;
  logic [4:0]      w_rs1_raw;
  logic [4:0]      w_rs2_raw;
  logic [31:0]     w_imm_i;
  logic [31:0]     w_imm_s;
  logic [31:0]     w_imm_b;
  logic [31:0]     w_imm_u;
  logic [31:0]     w_imm_j;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_wr_class;
  logic            w_writes_rd;
  logic            w_illegal;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rd;

  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_sb_next;
  logic [NREG-1:0] w_wb_mask;
  logic [NREG-1:0] w_pend_eff;
  logic            w_hazard;
  logic            w_in_fire;
  logic            w_out_fire;

  logic            r_out_valid;
  logic [XLEN-1:0] r_out_pc;
  logic [4:0]      r_out_rs1;
  logic [4:0]      r_out_rs2;
  logic [4:0]      r_out_rd;
  logic [XLEN-1:0] r_out_imm;
  logic [6:0]      r_out_opcode;
  logic [2:0]      r_out_funct3;
  logic [6:0]      r_out_funct7;
  logic            r_out_uses_rs1;
  logic            r_out_uses_rs2;
  logic            r_out_writes_rd;
  logic            r_out_illegal;

  assign w_opcode  = in_instr[6:0];
  assign w_rd_raw  = in_instr[11:7];
  assign w_rs1_raw = in_instr[19:15];
  assign w_rs2_raw = in_instr[24:20];

  assign w_imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign w_imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign w_imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                    in_instr[11:8], 1'b0};
  assign w_imm_u = {in_instr[31:12], 12'b0};
  assign w_imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                    in_instr[30:21], 1'b0};

  always_comb begin
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_wr_class = 1'b0;
    w_illegal  = 1'b0;
    w_imm32    = 32'd0;
    case (w_opcode)
      OPC_LUI, OPC_AUIPC: begin
        w_wr_class = 1'b1;
        w_imm32    = w_imm_u;
      end
      OPC_JAL: begin
        w_wr_class = 1'b1;
        w_imm32    = w_imm_j;
      end
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        w_uses_rs1 = 1'b1;
        w_wr_class = 1'b1;
        w_imm32    = w_imm_i;
      end
      OPC_BRANCH: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_imm32    = w_imm_b;
      end
      OPC_STORE: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_imm32    = w_imm_s;
      end
      OPC_OP: begin
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
        w_wr_class = 1'b1;
      end
      OPC_MISC, OPC_SYSTEM: begin
        w_imm32 = w_imm_i;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_imm       = {XLEN{w_imm32[31]}};
    w_imm[31:0] = w_imm32;
  end

  // x0 is never a real destination, so it neither reserves nor exposes an index.
  assign w_writes_rd = w_wr_class & (w_rd_raw != 5'd0);
  assign w_rs1       = w_uses_rs1  ? w_rs1_raw : 5'd0;
  assign w_rs2       = w_uses_rs2  ? w_rs2_raw : 5'd0;
  assign w_rd        = w_writes_rd ? w_rd_raw  : 5'd0;

  // A writeback landing this cycle already counts as released for issue.
  assign w_wb_mask  = wb_valid ? (NREG'(1) << wb_rd) : '0;
  assign w_pend_eff = r_sb & ~w_wb_mask;
  assign w_hazard   = (w_uses_rs1 & w_pend_eff[w_rs1]) | (w_uses_rs2 & w_pend_eff[w_rs2]);

  assign in_ready   = (~r_out_valid | out_ready) & ~w_hazard & ~flush;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  // Order matters: clears first, then the new reservation so a same-cycle set wins.
  always_comb begin
    w_sb_next = r_sb & ~w_wb_mask;
    if (flush && r_out_valid && r_out_writes_rd) begin
      w_sb_next = w_sb_next & ~(NREG'(1) << r_out_rd);
    end
    if (w_in_fire && w_writes_rd) begin
      w_sb_next = w_sb_next | (NREG'(1) << w_rd);
    end
    w_sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb <= '0;
    end else begin
      r_sb <= w_sb_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid     <= 1'b0;
      r_out_pc        <= '0;
      r_out_rs1       <= 5'd0;
      r_out_rs2       <= 5'd0;
      r_out_rd        <= 5'd0;
      r_out_imm       <= '0;
      r_out_opcode    <= 7'd0;
      r_out_funct3    <= 3'd0;
      r_out_funct7    <= 7'd0;
      r_out_uses_rs1  <= 1'b0;
      r_out_uses_rs2  <= 1'b0;
      r_out_writes_rd <= 1'b0;
      r_out_illegal   <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_out_valid     <= 1'b1;
      r_out_pc        <= in_pc;
      r_out_rs1       <= w_rs1;
      r_out_rs2       <= w_rs2;
      r_out_rd        <= w_rd;
      r_out_imm       <= w_imm;
      r_out_opcode    <= w_opcode;
      r_out_funct3    <= in_instr[14:12];
      r_out_funct7    <= in_instr[31:25];
      r_out_uses_rs1  <= w_uses_rs1;
      r_out_uses_rs2  <= w_uses_rs2;
      r_out_writes_rd <= w_writes_rd;
      r_out_illegal   <= w_illegal;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign out_pc        = r_out_pc;
  assign out_rs1       = r_out_rs1;
  assign out_rs2       = r_out_rs2;
  assign out_rd        = r_out_rd;
  assign out_imm       = r_out_imm;
  assign out_opcode    = r_out_opcode;
  assign out_funct3    = r_out_funct3;
  assign out_funct7    = r_out_funct7;
  assign out_uses_rs1  = r_out_uses_rs1;
  assign out_uses_rs2  = r_out_uses_rs2;
  assign out_writes_rd = r_out_writes_rd;
  assign out_illegal   = r_out_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table, directed hazard/hold/flush sequences,
// and a randomized run against a reference decoder and scoreboard model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic        out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;

  int n_pass = 0;
  int n_total = 0;

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
    .out_writes_rd(out_writes_rd), .out_illegal(out_illegal),
    .wb_valid(wb_valid), .wb_rd(wb_rd)
  );

  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; flush = 1'b0;
    out_ready = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference decoder ----------------
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        u1;
    logic        u2;
    logic        wr;
    logic        ill;
  } dec_t;

  function automatic dec_t ref_dec(input logic [31:0] ins);
    dec_t d;
    int s, top20, top25, sg;
    byte fmt;
    logic [4:0] rd_raw, rs1_raw, rs2_raw;
    s = ins;
    top20 = s >>> 20;
    top25 = s >>> 25;
    sg = s >>> 31;
    rd_raw  = 5'((ins >> 7) & 31);
    rs1_raw = 5'((ins >> 15) & 31);
    rs2_raw = 5'((ins >> 20) & 31);
    case (ins[6:0])
      7'h37, 7'h17:         fmt = "U";
      7'h6F:                fmt = "J";
      7'h67, 7'h03, 7'h13:  fmt = "I";
      7'h63:                fmt = "B";
      7'h23:                fmt = "S";
      7'h33:                fmt = "R";
      7'h0F, 7'h73:         fmt = "N";
      default:              fmt = "X";
    endcase
    d = '0;
    d.opc = ins[6:0];
    d.f3  = ins[14:12];
    d.f7  = ins[31:25];
    d.ill = (fmt == "X");
    case (fmt)
      "I", "N": d.imm = top20;
      "S":      d.imm = (top25 << 5) | int'((ins >> 7) & 31);
      "B":      d.imm = (sg << 12) | int'(((ins >> 7) & 1) << 11) |
                        int'(((ins >> 25) & 63) << 5) | int'(((ins >> 8) & 15) << 1);
      "U":      d.imm = ins & 32'hFFFF_F000;
      "J":      d.imm = (sg << 20) | int'(((ins >> 12) & 255) << 12) |
                        int'(((ins >> 20) & 1) << 11) | int'(((ins >> 21) & 1023) << 1);
      default:  d.imm = 32'd0;
    endcase
    d.u1 = (fmt == "I") || (fmt == "B") || (fmt == "S") || (fmt == "R");
    d.u2 = (fmt == "B") || (fmt == "S") || (fmt == "R");
    d.wr = ((fmt == "U") || (fmt == "J") || (fmt == "I") || (fmt == "R")) && (rd_raw != 0);
    d.rs1 = d.u1 ? rs1_raw : 5'd0;
    d.rs2 = d.u2 ? rs2_raw : 5'd0;
    d.rd  = d.wr ? rd_raw  : 5'd0;
    return d;
  endfunction

  function automatic logic [127:0] dut_bundle();
    dec_t d;
    d = '{out_rs1, out_rs2, out_rd, out_imm, out_opcode, out_funct3, out_funct7,
          out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal};
    return {28'd0, d, out_pc};
  endfunction

  // ---------------- decode vector table ----------------
  typedef struct {
    logic [31:0] ins;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        u1, u2, wr, ill;
  } vec_t;

  vec_t vecs[16];

  task automatic fill_vecs();
    vecs[0]  = '{32'h00500093, 5'd0, 5'd0, 5'd1, 32'h00000005, 1, 0, 1, 0}; // addi x1,x0,5
    vecs[1]  = '{32'h00108133, 5'd1, 5'd1, 5'd2, 32'h00000000, 1, 1, 1, 0}; // add x2,x1,x1
    vecs[2]  = '{32'hFE20AE23, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 1, 1, 0, 0}; // sw x2,-4(x1)
    vecs[3]  = '{32'h00000000, 5'd0, 5'd0, 5'd0, 32'h00000000, 0, 0, 0, 1}; // illegal
    vecs[4]  = '{32'h00000013, 5'd0, 5'd0, 5'd0, 32'h00000000, 1, 0, 0, 0}; // nop
    vecs[5]  = '{32'h123452B7, 5'd0, 5'd0, 5'd5, 32'h12345000, 0, 0, 1, 0}; // lui x5
    vecs[6]  = '{32'hFE208CE3, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8, 1, 1, 0, 0}; // beq -8
    vecs[7]  = '{32'h001000EF, 5'd0, 5'd0, 5'd1, 32'h00000800, 0, 0, 1, 0}; // jal x1,2048
    vecs[8]  = '{32'hFFFFF06F, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE, 0, 0, 0, 0}; // jal x0,-2
    vecs[9]  = '{32'h000280E7, 5'd5, 5'd0, 5'd1, 32'h00000000, 1, 0, 1, 0}; // jalr x1,0(x5)
    vecs[10] = '{32'h7FF3A303, 5'd7, 5'd0, 5'd6, 32'h000007FF, 1, 0, 1, 0}; // lw max imm
    vecs[11] = '{32'hFFFFF217, 5'd0, 5'd0, 5'd4, 32'hFFFFF000, 0, 0, 1, 0}; // auipc x4
    vecs[12] = '{32'h00000073, 5'd0, 5'd0, 5'd0, 32'h00000000, 0, 0, 0, 0}; // ecall
    vecs[13] = '{32'h0FF0000F, 5'd0, 5'd0, 5'd0, 32'h000000FF, 0, 0, 0, 0}; // fence
    vecs[14] = '{32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'h00000000, 0, 0, 0, 1}; // opcode 7F
    vecs[15] = '{32'h405201B3, 5'd4, 5'd5, 5'd3, 32'h00000000, 1, 1, 1, 0}; // sub x3,x4,x5
  endtask

  // ---------------- random-run model state ----------------
  bit   m_pend[32];
  bit   m_ov;
  dec_t m_b;
  logic [31:0] m_pc;

  logic [31:0] opc_pool[12] = '{32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h03,
                                32'h23, 32'h13, 32'h33, 32'h0F, 32'h73, 32'h00};

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [31:0] op;
    int k;
    ins = $urandom;
    k = $urandom_range(0, 12);
    op = (k == 12) ? 32'($urandom_range(0, 127)) : opc_pool[k];
    ins[6:0]   = op[6:0];
    ins[11:7]  = 5'($urandom_range(0, 7));
    ins[19:15] = 5'($urandom_range(0, 7));
    ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    logic [127:0] exp_b;
    dec_t d;
    bit   m_ready, fire_in;
    bit   eff[32];

    // ---- test 1: reset state and first decode ----
    do_reset();
    check("rst out_valid", out_valid, 0);
    check("rst in_ready", in_ready, 1);
    check("rst out_pc", out_pc, 0);
    check("rst out_imm", out_imm, 0);
    check("rst out_rd", out_rd, 0);
    in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h100;
    #2 check("t1 in_ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("t1 out_valid", out_valid, 1);
    check("t1 fields", {out_rd, out_rs1, out_imm, out_uses_rs2, out_writes_rd, out_pc},
          {5'd1, 5'd0, 32'd5, 1'b0, 1'b1, 32'h100});

    // ---- test 2: RAW stall on x1 released by same-cycle writeback ----
    in_valid = 1; in_instr = 32'h00108133; in_pc = 32'h104; out_ready = 1;
    #2 check("t2 stall a", in_ready, 0);
    tick();
    check("t2 out drained", out_valid, 0);
    #1 check("t2 stall b", in_ready, 0);
    wb_valid = 1; wb_rd = 5'd1;
    #1 check("t2 wb unblock", in_ready, 1);
    tick();
    wb_valid = 0; in_valid = 0;
    check("t2 bundle", {out_valid, out_rs1, out_rs2, out_rd, out_pc},
          {1'b1, 5'd1, 5'd1, 5'd2, 32'h104});

    // ---- test 3: store decode, no reservation for its rd field ----
    in_valid = 1; in_instr = 32'hFE20AE23; in_pc = 32'h108;
    wb_valid = 1; wb_rd = 5'd2;
    #2 check("t3 in_ready", in_ready, 1);
    tick();
    wb_valid = 0; in_valid = 0;
    check("t3 bundle", {out_imm, out_rs1, out_rs2, out_writes_rd, out_rd},
          {32'hFFFFFFFC, 5'd1, 5'd2, 1'b0, 5'd0});
    in_valid = 1; in_instr = 32'h000E02B3; in_pc = 32'h10C;
    #2 check("t3 x28 free", in_ready, 1);
    tick();
    in_valid = 0;
    tick();
    wb_valid = 1; wb_rd = 5'd5;
    tick();
    wb_valid = 0;

    // ---- test 4: output hold then back-to-back accept ----
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00100413; in_pc = 32'h200;
    tick();
    in_instr = 32'h00200493; in_pc = 32'h204;
    for (int c = 0; c < 3; c++) begin
      #2 check("t4 hold ready", in_ready, 0);
      tick();
      check("t4 hold bundle", {out_valid, out_pc, out_rd, out_imm},
            {1'b1, 32'h200, 5'd8, 32'd1});
    end
    out_ready = 1;
    #2 check("t4 b2b ready", in_ready, 1);
    tick();
    in_valid = 0;
    check("t4 next bundle", {out_valid, out_pc, out_rd, out_imm},
          {1'b1, 32'h204, 5'd9, 32'd2});
    wb_valid = 1; wb_rd = 5'd8;
    tick();
    wb_rd = 5'd9;
    tick();
    wb_valid = 0;

    // ---- test 6: flush releases the held destination ----
    out_ready = 0;
    in_valid = 1; in_instr = 32'h00700193; in_pc = 32'h300;
    tick();
    in_valid = 0;
    check("t6 held", {out_valid, out_rd}, {1'b1, 5'd3});
    tick();
    flush = 1; in_valid = 1; in_instr = 32'h00318233; in_pc = 32'h304;
    #2 check("t6 flush blocks", in_ready, 0);
    tick();
    flush = 0;
    check("t6 flushed", out_valid, 0);
    #1 check("t6 x3 released", in_ready, 1);
    tick();
    in_valid = 0;
    check("t6 accepted", {out_valid, out_pc, out_rs1, out_rs2, out_rd},
          {1'b1, 32'h304, 5'd3, 5'd3, 5'd4});

    // ---- decode vector table (test 5 cases included) ----
    do_reset();
    fill_vecs();
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_instr = vecs[i].ins; in_pc = 32'h1000 + 32'(i * 4);
      #2 check($sformatf("vec%0d ready", i), in_ready, 1);
      tick();
      in_valid = 0;
      check($sformatf("vec%0d decode", i),
            {out_valid, out_rs1, out_rs2, out_rd, out_imm, out_uses_rs1, out_uses_rs2,
             out_writes_rd, out_illegal, out_opcode},
            {1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm, vecs[i].u1,
             vecs[i].u2, vecs[i].wr, vecs[i].ill, vecs[i].ins[6:0]});
      wb_valid = 1; wb_rd = vecs[i].ins[11:7];
      tick();
      wb_valid = 0;
    end

    // ---- randomized run against the model ----
    do_reset();
    foreach (m_pend[r]) m_pend[r] = 0;
    m_ov = 0; m_b = '0; m_pc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd out_valid", out_valid, m_ov);
      if (m_ov) check("rnd bundle", dut_bundle(), {28'd0, m_b, m_pc});
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      out_ready = ($urandom_range(0, 2) != 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      d = ref_dec(in_instr);
      foreach (eff[r]) eff[r] = m_pend[r] && !(wb_valid && wb_rd == r);
      m_ready = (!m_ov || out_ready) && !flush &&
                !(d.u1 && eff[d.rs1]) && !(d.u2 && eff[d.rs2]);
      #2 check("rnd in_ready", in_ready, m_ready);
      fire_in = in_valid && m_ready;
      if (wb_valid) m_pend[wb_rd] = 0;
      if (flush && m_ov && m_b.wr) m_pend[m_b.rd] = 0;
      if (fire_in && d.wr) m_pend[d.rd] = 1;
      m_pend[0] = 0;
      if (flush) m_ov = 0;
      else if (fire_in) begin
        m_ov = 1; m_b = d; m_pc = in_pc;
      end else if (m_ov && out_ready) m_ov = 0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
